// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RISC-V field/immediate decode registered behind a 2-entry skid buffer.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit AUTO_IMM = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic [2:0]      immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] immext,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            ill;
    } entry_t;

    logic [2:0]      auto_fmt, fmt;
    logic            auto_ill;
    logic [31:0]     imm32;
    logic [XLEN-1:0] shamt, imm;
    entry_t          in_e, main_q, main_d, skid_q, skid_d;
    logic            main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, take, pop;

    always_comb begin
        auto_fmt = 3'd7;
        auto_ill = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b1100111: auto_fmt = 3'd0;
            7'b0010011:             auto_fmt = (instr[13:12] == 2'b01) ? 3'd6 : 3'd0;
            7'b0100011:             auto_fmt = 3'd1;
            7'b1100011:             auto_fmt = 3'd2;
            7'b1101111:             auto_fmt = 3'd3;
            7'b0110111, 7'b0010111: auto_fmt = 3'd4;
            7'b1110011:             auto_fmt = instr[14] ? 3'd5 : 3'd0;
            7'b0110011:             auto_fmt = 3'd7;
            default:                auto_ill = 1'b1;
        endcase
    end

    assign fmt = AUTO_IMM ? auto_fmt : immsrc;

    // Sign-extending formats are built at 32 bits, then widened by a signed cast.
    always_comb begin
        imm32 = '0;
        case (fmt)
            3'd0: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'd1: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'd4: imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign shamt = (XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
    assign imm   = (fmt == 3'd5) ? XLEN'(instr[19:15]) :
                   (fmt == 3'd6) ? shamt : XLEN'($signed(imm32));
    assign in_e  = '{instr: instr, imm: imm, pc: pc_in, ill: AUTO_IMM ? auto_ill : 1'b0};

    assign take = in_valid & rdy_q;
    assign pop  = main_v_q & out_ready;

    // Main refills from skid first so order is kept; skid only fills while main stalls.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || pop) begin
            main_v_d = skid_v_q | take;
            main_d   = skid_v_q ? skid_q : take ? in_e : main_q;
            skid_v_d = 1'b0;
        end else if (take) begin
            skid_v_d = 1'b1;
            skid_d   = in_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= ~skid_v_d;
        end
    end

    always_ff @(posedge clk) skid_q <= skid_d;

    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign op        = main_q.instr[6:0];
    assign rd        = main_q.instr[11:7];
    assign funct3    = main_q.instr[14:12];
    assign rs1       = main_q.instr[19:15];
    assign rs2       = main_q.instr[24:20];
    assign funct7    = main_q.instr[31:25];
    assign immext    = main_q.imm;
    assign pc_out    = main_q.pc;
    assign illegal   = main_q.ill;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: random and directed checks of imm_decode_stage against a queue model.
module tb_imm_decode_stage;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, ill;
    logic [31:0] instr = '0, pc_in = '0, imm, pco;
    logic [2:0] src0 = 3'd0, f3;
    logic [6:0] opc, f7;
    logic [4:0] rs1, rs2, rd;

    logic v2 = 1'b0, rdy2 = 1'b1;
    logic [31:0] instr2 = '0;
    logic [63:0] pc2 = '0;
    logic [2:0] src2 = '0;
    logic b_ir, b_ov, b_ill, c_ir, c_ov, c_ill;
    logic [2:0] b_f3, c_f3;
    logic [6:0] b_op, b_f7, c_op, c_f7;
    logic [4:0] b_rs1, b_rs2, b_rd, c_rs1, c_rs2, c_rd;
    logic [63:0] b_imm, b_pc;
    logic [31:0] c_imm, c_pc;

    int checks = 0, failures = 0;

    typedef struct { logic [31:0] i; logic [31:0] pc; } ent_t;
    ent_t q[$];
    bit fresh;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .AUTO_IMM(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .immsrc(src0), .out_valid(out_valid), .out_ready(out_ready),
        .op(opc), .funct3(f3), .funct7(f7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .immext(imm), .pc_out(pco), .illegal(ill));

    imm_decode_stage #(.XLEN(64), .AUTO_IMM(1'b1)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(v2), .in_ready(b_ir),
        .instr(instr2), .pc_in(pc2), .immsrc(src2), .out_valid(b_ov), .out_ready(rdy2),
        .op(b_op), .funct3(b_f3), .funct7(b_f7), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
        .immext(b_imm), .pc_out(b_pc), .illegal(b_ill));

    imm_decode_stage #(.XLEN(32), .AUTO_IMM(1'b0)) dutm (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(v2), .in_ready(c_ir),
        .instr(instr2), .pc_in(pc2[31:0]), .immsrc(src2), .out_valid(c_ov), .out_ready(rdy2),
        .op(c_op), .funct3(c_f3), .funct7(c_f7), .rs1(c_rs1), .rs2(c_rs2), .rd(c_rd),
        .immext(c_imm), .pc_out(c_pc), .illegal(c_ill));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Immediate as a plain integer from the instruction-set rules, truncated to the datapath width.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input bit x64, input bit auto_f,
                                            input logic [2:0] src, output bit bad);
        int f;
        longint v;
        bad = 1'b0;
        f = int'(src);
        if (auto_f) begin
            case (i[6:0])
                7'h03, 7'h67: f = 0;
                7'h13: f = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 6 : 0;
                7'h23: f = 1;
                7'h63: f = 2;
                7'h6F: f = 3;
                7'h37, 7'h17: f = 4;
                7'h73: f = i[14] ? 5 : 0;
                7'h33: f = 7;
                default: begin f = 7; bad = 1'b1; end
            endcase
        end
        case (f)
            0: v = longint'($signed(i[31:20]));
            1: v = longint'($signed({i[31:25], i[11:7]}));
            2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
            3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
            4: v = longint'($signed(i[31:12])) * 4096;
            5: v = longint'(i[19:15]);
            6: v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
            default: v = 0;
        endcase
        return x64 ? 64'(v) : {32'b0, v[31:0]};
    endfunction

    task automatic verify();
        bit eb;
        logic [63:0] e;
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            e = ref_imm(q[0].i, 1'b0, 1'b1, 3'd0, eb);
            check("immext", imm, e);
            check("illegal", ill, eb);
            check("pc_out", pco, q[0].pc);
            check("fields", {f7, rs2, rs1, f3, rd, opc}, q[0].i);
        end else if (fresh) begin
            check("rst_imm_pc", {imm, pco}, 64'd0);
            check("rst_fields", {f7, rs2, rs1, f3, rd, opc, ill}, 64'd0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            q.delete();
            fresh = 1'b1;
        end else if (flush) q.delete();
        else begin
            bit can_take;
            can_take = q.size() < 2;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && can_take) begin
                q.push_back('{instr, pc_in});
                fresh = 1'b0;
            end
        end
        @(negedge clk);
        verify();
    endtask

    task automatic t2(input logic [31:0] x, input logic [2:0] s);
        bit eb;
        logic [63:0] e;
        v2 = 1'b1;
        instr2 = x;
        src2 = s;
        pc2 = {$urandom, $urandom};
        cyc();
        v2 = 1'b0;
        check("x64_valid", b_ov, 1'b1);
        e = ref_imm(x, 1'b1, 1'b1, s, eb);
        check("x64_imm", b_imm, e);
        check("x64_ill", b_ill, eb);
        check("x64_pc", b_pc, pc2);
        check("x64_fields", {b_f7, b_rs2, b_rs1, b_f3, b_rd, b_op}, x);
        e = ref_imm(x, 1'b0, 1'b0, s, eb);
        check("man_valid", c_ov, 1'b1);
        check("man_imm", c_imm, e);
        check("man_ill", c_ill, 1'b0);
        check("man_pc", c_pc, pc2[31:0]);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [10] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33};
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) r[6:0] = ops[k];
        return r;
    endfunction

    localparam logic [31:0] IA = 32'h0050_0113, IB = 32'h00A0_0193, IC = 32'h7FF0_0213;

    initial begin
        fresh = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        instr = 32'hFFF0_0093; pc_in = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("addi_imm", imm, 32'hFFFF_FFFF);
        check("addi_rd", rd, 5'd1);
        check("addi_ill", ill, 1'b0);
        cyc();

        out_ready = 1'b0; in_valid = 1'b1; instr = IA;
        cyc();
        instr = IB;
        cyc();
        in_valid = 1'b0;
        check("skid_rdy", in_ready, 1'b0);
        check("skid_a", rd, 5'd2);
        out_ready = 1'b1;
        cyc();
        check("drain_b", rd, 5'd3);
        check("drain_rdy", in_ready, 1'b1);
        cyc();
        check("drained", out_valid, 1'b0);

        out_ready = 1'b0; in_valid = 1'b1; instr = IA;
        cyc();
        instr = IB;
        cyc();
        instr = IC; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_ov", out_valid, 1'b0);
        check("flush_rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        cyc();
        cyc();

        instr = 32'h0000_007F; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("bad_op_ill", ill, 1'b1);
        check("bad_op_imm", imm, 32'd0);
        cyc();

        out_ready = 1'b0; in_valid = 1'b1; instr = IA;
        cyc();
        instr = IB;
        cyc();
        in_valid = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_stall_ov", out_valid, 1'b0);
        check("rst_stall_rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        cyc();

        t2(32'h03F1_1093, 3'd6);
        check("slli63", b_imm, 64'd63);
        t2(32'h8000_00EF, 3'd3);
        check("jal_neg", b_imm, 64'hFFFF_FFFF_FFF0_0000);
        t2(32'h1234_5037, 3'd4);
        check("man_u", c_imm, 64'h1234_5000);
        for (int n = 0; n < 40; n++) t2(rnd_instr(), 3'($urandom_range(0, 7)));
        cyc();

        for (int n = 0; n < 3000; n++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 63) == 0;
            reset = $urandom_range(0, 255) == 0;
            instr = rnd_instr();
            pc_in = $urandom;
            cyc();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();
        check("final_empty", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
